// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions used by the EX-stage multiply sequencer.
//   mul_state_t : multiplier controller states (IDLE, RUN, DONE)
//   ALU_MUL     : ALUControl encoding that selects the multiplier
//   DATA_W      : datapath width of the core
// ----------------------------------------------------------------------------
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mul_state_t;

   localparam logic [2:0] ALU_MUL = 3'b010;
   localparam int         DATA_W  = 32;

endpackage

// File: rtl/mul_datapath.sv
// ----------------------------------------------------------------------------
// mul_datapath
// Shift-add multiplier datapath: accumulator, shifting multiplicand and
// shifting multiplier. One multiplier bit is consumed per step.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset (clears all regs)
//   load_i           : capture a_i/b_i and clear the accumulator
//   step_i           : perform one shift-add iteration
//   a_i, b_i         : multiplicand / multiplier operands
//   acc_o            : running (and final) low WIDTH bits of the product
//   b_rest_zero_o    : multiplier bits above bit 0 are all zero, i.e. the
//                      current step is the last one that can change acc
// ----------------------------------------------------------------------------
module mul_datapath
   import cpu_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] acc_o,
   output logic             b_rest_zero_o
);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;

   always_comb begin
      acc_d = acc_q;
      a_d   = a_q;
      b_d   = b_q;
      if (load_i) begin
         acc_d = '0;
         a_d   = a_i;
         b_d   = b_i;
      end else if (step_i) begin
         // Sum wraps naturally: only the low WIDTH bits of a*b are kept.
         if (b_q[0]) begin
            acc_d = acc_q + a_q;
         end
         a_d = a_q << 1;
         b_d = b_q >> 1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
      end else begin
         acc_q <= acc_d;
         a_q   <= a_d;
         b_q   <= b_d;
      end
   end

   assign acc_o         = acc_q;
   assign b_rest_zero_o = (b_q[WIDTH-1:1] == '0);

endmodule

// File: rtl/mul_sequencer.sv
// ----------------------------------------------------------------------------
// mul_sequencer
// Iterative shift-add multiplier controller for the EX stage. Latches the
// operands, runs one multiplier bit per cycle while stalling the pipeline,
// then presents the product and N/Z flags for a single done_o cycle.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   start_i        : EX holds a valid MUL (held high through DONE)
//   flush_i        : EX instruction squashed; abort back to IDLE
//   set_flags_i    : S bit of the MUL, captured at start
//   a_i, b_i       : multiplicand / multiplier
//   stall_o        : hold IF/ID/EX pipeline registers
//   done_o         : one-cycle pulse, result_o and flags valid
//   result_o       : low WIDTH bits of a*b (held between done pulses)
//   flag_n_o       : result_o[WIDTH-1]
//   flag_z_o       : result_o == 0
//   flag_we_o      : write N/Z (done_o & captured S bit); C/V never written
// Build option:
//   MUL_EARLY_TERM_EN : leave RUN as soon as the remaining multiplier bits
//                       are zero; latency becomes 2 + msb index of b_i.
// ----------------------------------------------------------------------------
module mul_sequencer
   import cpu_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start_i,
   input  logic             flush_i,
   input  logic             set_flags_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             stall_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             flag_n_o,
   output logic             flag_z_o,
   output logic             flag_we_o
);

`ifdef MUL_EARLY_TERM_EN
   localparam bit EARLY_TERM = 1'b1;
`else
   localparam bit EARLY_TERM = 1'b0;
`endif

   function automatic logic is_zero(input logic [WIDTH-1:0] v);
      return (v == '0);
   endfunction

   mul_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             s_q, s_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             n_q, n_d;
   logic             z_q, z_d;

   logic             load;
   logic             step;
   logic             stall;
   logic             done;
   logic             go;
   logic             run_last;
   logic [WIDTH-1:0] acc;
   logic             b_rest_zero;

   mul_datapath #(
      .WIDTH(WIDTH)
   ) u_datapath (
      .clk           (clk),
      .reset_n       (reset_n),
      .load_i        (load),
      .step_i        (step),
      .a_i           (a_i),
      .b_i           (b_i),
      .acc_o         (acc),
      .b_rest_zero_o (b_rest_zero)
   );

   assign go       = start_i & ~flush_i;
   assign run_last = (cnt_q == CNT_W'(WIDTH - 1)) | (EARLY_TERM & b_rest_zero);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      s_d     = s_q;
      load    = 1'b0;
      step    = 1'b0;
      stall   = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            // Combinational so EX holds in the very cycle the MUL arrives.
            stall = go;
            if (go) begin
               load    = 1'b1;
               cnt_d   = '0;
               s_d     = set_flags_i;
               state_d = RUN;
            end
         end
         RUN: begin
            stall = 1'b1;
            step  = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (run_last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // start_i is still high here for the same MUL; ignore it.
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush_i) begin
         state_d = IDLE;
         stall   = 1'b0;
         done    = 1'b0;
      end
   end

   // Hold the last delivered product/flags between done pulses.
   assign res_d = done ? acc : res_q;
   assign n_d   = done ? acc[WIDTH-1] : n_q;
   assign z_d   = done ? is_zero(acc) : z_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         s_q     <= 1'b0;
         res_q   <= '0;
         n_q     <= 1'b0;
         z_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
         res_q   <= res_d;
         n_q     <= n_d;
         z_q     <= z_d;
      end
   end

   // stall is gated by reset_n so every output reads 0 while in reset,
   // even if start_i is already high.
   assign stall_o   = stall & reset_n;
   assign done_o    = done;
   assign result_o  = done ? acc : res_q;
   assign flag_n_o  = done ? acc[WIDTH-1] : n_q;
   assign flag_z_o  = done ? is_zero(acc) : z_q;
   assign flag_we_o = done & s_q;

endmodule
